// File: rtl/sum_parity_checker.sv
// sum_parity_checker: checks each accepted sum/parity pair. Good samples are
// added to a running accumulator, and bad samples are counted. One result per
// accepted sample is queued in a small FIFO, which drains over valid/ready.
module sum_parity_checker #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int DEPTH  = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_parity,
  input  logic              acc_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_count,
  output logic              acc_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ACC_W-1:0] mem_data_q [DEPTH];
  logic             mem_err_q  [DEPTH];

  logic             full, empty, accept, pop, mismatch;
  logic [ACC_W-1:0] acc_base, push_data;
  logic [ACC_W:0]   acc_sum;

  // Handshake and FIFO status. While in reset, no sample is accepted.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = !full && !rst;
    out_valid = !empty;
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Parity check, accumulator update, error counter and the value to be pushed.
  // In a clear cycle, the accumulator starts from zero.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    mismatch    = ((^in_sum) != in_parity);
    acc_base    = acc_clear ? '0 : acc_q;
    acc_sum     = {1'b0, acc_base} + (ACC_W+1)'(in_sum);
    acc_d       = acc_base;
    acc_ovf_d   = acc_ovf_q && !acc_clear;
    err_count_d = err_count_q;
    push_data   = acc_base;
    if (accept) begin
      if (mismatch) begin
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      end else begin
        acc_d     = acc_sum[ACC_W-1:0];
        push_data = acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W]) acc_ovf_d = 1'b1;
      end
    end
  end

  // Pointer and occupancy bookkeeping. The pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Head of the FIFO. An empty FIFO reads as zero, so the storage itself needs no reset.
  always_comb begin
    out_data = empty ? '0 : mem_data_q[rd_ptr_q];
    out_err  = !empty && mem_err_q[rd_ptr_q];
  end

  assign err_count = err_count_q;
  assign acc_ovf   = acc_ovf_q;

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      err_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      err_count_q <= err_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is left unreset on purpose; the empty-gated read above hides stale contents.
    if (accept) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_err_q[wr_ptr_q]  <= mismatch;
    end
  end

endmodule
